// File: rtl/d_pkg.sv
// Shared definitions for the d_join_alu CGRA stage: op encodings and default op-select width.
// Pure constants; no logic.
package d_pkg;

    localparam int D_OP_WIDTH = 4;

    localparam logic [D_OP_WIDTH-1:0] OP_ADD    = 4'd0;
    localparam logic [D_OP_WIDTH-1:0] OP_SUB    = 4'd1;
    localparam logic [D_OP_WIDTH-1:0] OP_MUL    = 4'd2;
    localparam logic [D_OP_WIDTH-1:0] OP_AND    = 4'd3;
    localparam logic [D_OP_WIDTH-1:0] OP_OR     = 4'd4;
    localparam logic [D_OP_WIDTH-1:0] OP_XOR    = 4'd5;
    localparam logic [D_OP_WIDTH-1:0] OP_SHL    = 4'd6;
    localparam logic [D_OP_WIDTH-1:0] OP_SHR    = 4'd7;
    localparam logic [D_OP_WIDTH-1:0] OP_ASR    = 4'd8;
    localparam logic [D_OP_WIDTH-1:0] OP_LT     = 4'd9;
    localparam logic [D_OP_WIDTH-1:0] OP_EQ     = 4'd10;
    localparam logic [D_OP_WIDTH-1:0] OP_PASS_A = 4'd11;
    localparam logic [D_OP_WIDTH-1:0] OP_PASS_B = 4'd12;

endpackage

// File: rtl/d_alu.sv
// Combinational two-operand ALU, zero latency, no handshake.
// Shifts use only the low log2(DATA_WIDTH) bits of b; unused op codes yield 0.
module d_alu
    import d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = D_OP_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0]       sh;
    logic [DATA_WIDTH-1:0] prod;
    logic                  lt;
    logic                  eq;

    assign sh   = b[SH_W-1:0];
    assign prod = a * b;
    assign lt   = $signed(a) < $signed(b);
    assign eq   = (a == b);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:    y = a + b;
            OP_SUB:    y = a - b;
            OP_MUL:    y = prod;
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_SHL:    y = a << sh;
            OP_SHR:    y = a >> sh;
            OP_ASR:    y = $unsigned($signed(a) >>> sh);
            OP_LT:     y = {{(DATA_WIDTH-1){1'b0}}, lt};
            OP_EQ:     y = {{(DATA_WIDTH-1){1'b0}}, eq};
            OP_PASS_A: y = a;
            OP_PASS_B: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/d_join_alu.sv
// Joins two operand streams, applies the configured ALU op, and buffers results in main+skid registers.
// One cycle fire-to-dout latency; ready toward upstream depends only on skid occupancy, never on dout_r.
module d_join_alu
    import d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = D_OP_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  din1_v,
    output logic                  din1_r,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic                  din2_v,
    output logic                  din2_r,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_v,
    input  logic                  dout_r
);

    logic [DATA_WIDTH-1:0] skid_d;
    logic                  skid_v;
    logic [DATA_WIDTH-1:0] result;
    logic                  space;
    logic                  fire;

    // Each side's ready waits for the other's valid so the pair moves atomically.
    assign space  = ~skid_v;
    assign fire   = din1_v & din2_v & space;
    assign din1_r = space & din2_v;
    assign din2_r = space & din1_v;

    d_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_alu (
        .a  (din1),
        .b  (din2),
        .op (op),
        .y  (result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout   <= '0;
            dout_v <= 1'b0;
            skid_d <= '0;
            skid_v <= 1'b0;
        end else if (dout_v && dout_r) begin
            // Skid holds the older result, and fire is blocked while it is occupied.
            if (skid_v) begin
                dout   <= skid_d;
                skid_v <= 1'b0;
            end else if (fire) begin
                dout <= result;
            end else begin
                dout_v <= 1'b0;
            end
        end else if (!dout_v) begin
            if (fire) begin
                dout   <= result;
                dout_v <= 1'b1;
            end
        end else if (fire) begin
            skid_d <= result;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: tb/tb_d_join_alu.sv
// Directed bench for d_join_alu with an in-order scoreboard on every output handshake.
// Inputs change 1ns after posedge; the monitor samples on negedge.
module tb_d_join_alu;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] din1, din2;
    logic        din1_v, din2_v;
    logic        din1_r, din2_r;
    logic [3:0]  op;
    logic [31:0] dout;
    logic        dout_v;
    logic        dout_r;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_dout = '0;

    always #5 clock = ~clock;

    d_join_alu #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .din1   (din1),
        .din1_v (din1_v),
        .din1_r (din1_r),
        .din2   (din2),
        .din2_v (din2_v),
        .din2_r (din2_r),
        .op     (op),
        .dout   (dout),
        .dout_v (dout_v),
        .dout_r (dout_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  s;
        s = b[4:0];
        p = {32'd0, a} * {32'd0, b};
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return p[31:0];
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return a << s;
            4'd7:  return a >> s;
            4'd8:  begin
                       logic [63:0] ext;
                       ext = {{32{a[31]}}, a} >> s;
                       return ext[31:0];
                   end
            4'd9:  return (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            4'd10: return ((a == b) ? 32'd1 : 32'd0);
            4'd11: return a;
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard: pop on output handshake, push on fire, and hold-check across stalls.
    always @(negedge clock) begin
        if (mon_en && reset) begin
            if (stall_prev) begin
                check("stall_hold_v", {31'd0, dout_v}, 32'd1);
                check("stall_hold_d", dout, prev_dout);
            end
            if (dout_v && dout_r) begin
                if (exp_q.size() == 0) check("unexpected_out", dout, 32'hDEAD_BEEF);
                else check("sb_data", dout, exp_q.pop_front());
            end
            if (din1_v && din1_r) begin
                check("join_pair", {31'd0, din2_v && din2_r}, 32'd1);
                exp_q.push_back(ref_alu(op, din1, din2));
            end
            stall_prev = dout_v && !dout_r;
            prev_dout  = dout;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        op = o; din1 = a; din2 = b; din1_v = 1'b1; din2_v = 1'b1; dout_r = 1'b1;
        step();
        din1_v = 1'b0; din2_v = 1'b0;
        check(tag, dout, exp);
        step();
    endtask

    task automatic drain();
        din1_v = 1'b0; din2_v = 1'b0; dout_r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_q.size() == 0 && !dout_v) break;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", {31'd0, dout_v}, 32'd0);
    endtask

    initial begin
        int k;
        int stall_fires;
        logic fired;

        reset = 1'b0; din1 = '0; din2 = '0; din1_v = 1'b0; din2_v = 1'b1; op = 4'd0; dout_r = 1'b0;
        #1;
        check("rst_dout_v", {31'd0, dout_v}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_din1_r", {31'd0, din1_r}, 32'd1);
        check("rst_din2_r", {31'd0, din2_r}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Fill main and skid, then reset mid-cycle.
        op = 4'd0; din1 = 32'd3; din2 = 32'd4; din1_v = 1'b1; din2_v = 1'b1; dout_r = 1'b0;
        step();
        step();
        check("fill_dout", dout, 32'd7);
        check("fill_skid_full", {31'd0, din1_r}, 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_rst_v", {31'd0, dout_v}, 32'd0);
        check("async_rst_skid", {31'd0, din1_r}, 32'd1);
        step();
        check("in_rst_v", {31'd0, dout_v}, 32'd0);
        reset = 1'b1;
        #1;
        check("rel_din1_r", {31'd0, din1_r}, 32'd1);
        step();
        check("rel_sum", dout, 32'd7);
        check("rel_sum_v", {31'd0, dout_v}, 32'd1);
        din1_v = 1'b0; din2_v = 1'b0; dout_r = 1'b1;
        step();
        check("rel_drained", {31'd0, dout_v}, 32'd0);
        mon_en = 1'b1;

        // Op coverage.
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run_op("sub_neg", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_op("mul_wrap", 4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0);
        run_op("mul", 4'd2, 32'd7, 32'd6, 32'd42);
        run_op("and", 4'd3, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034);
        run_op("or", 4'd4, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        run_op("xor", 4'd5, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        run_op("shl", 4'd6, 32'h8000_0000, 32'd4, 32'd0);
        run_op("shl_hi_b", 4'd6, 32'd1, 32'h0000_0023, 32'd8);
        run_op("shr", 4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_op("asr", 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_op("lt_true", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_op("lt_false", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("eq_true", 4'd10, 32'd5, 32'd5, 32'd1);
        run_op("eq_false", 4'd10, 32'd5, 32'd6, 32'd0);
        run_op("pass_a", 4'd11, 32'h1234_5678, 32'd9, 32'h1234_5678);
        run_op("pass_b", 4'd12, 32'h1234_5678, 32'd9, 32'd9);
        run_op("op14", 4'd14, 32'h1234_5678, 32'd9, 32'd0);

        // Back-to-back streaming, no bubbles.
        op = 4'd0; dout_r = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din1 = 32'(i * 7); din2 = 32'(i); din1_v = 1'b1; din2_v = 1'b1;
            #1;
            check("stream_rdy", {31'd0, din1_r}, 32'd1);
            step();
            check("stream_v", {31'd0, dout_v}, 32'd1);
            check("stream_d", dout, 32'(i * 8));
        end
        drain();

        // Join skew: operand A waits for B.
        op = 4'd0; din1 = 32'd10; din2 = 32'd3; din1_v = 1'b1; din2_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("skew_din1_r", {31'd0, din1_r}, 32'd0);
            check("skew_din2_r", {31'd0, din2_r}, 32'd1);
            step();
            check("skew_no_out", {31'd0, dout_v}, 32'd0);
        end
        din2_v = 1'b1;
        #1;
        check("skew_join_rdy", {31'd0, din1_r}, 32'd1);
        step();
        din1_v = 1'b0; din2_v = 1'b0;
        check("skew_sum", dout, 32'd13);
        step();
        check("skew_single", {31'd0, dout_v}, 32'd0);

        // Backpressure: dout_r low for cycles 5..8.
        op = 4'd1; k = 0; stall_fires = 0;
        for (int c = 0; c < 20; c++) begin
            dout_r = !(c >= 5 && c < 9);
            din1 = 32'(1000 + 3 * k); din2 = 32'(k); din1_v = 1'b1; din2_v = 1'b1;
            #1;
            fired = din1_r;
            if (c >= 5 && c < 9) stall_fires += int'(fired);
            if (c >= 6 && c < 9) begin
                check("bp_din1_r", {31'd0, din1_r}, 32'd0);
                check("bp_din2_r", {31'd0, din2_r}, 32'd0);
            end
            step();
            if (fired) k++;
        end
        check("bp_skid_fires", 32'(stall_fires), 32'd1);
        drain();

        // Random handshakes against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            din1_v = 1'($urandom_range(0, 1));
            din2_v = 1'($urandom_range(0, 1));
            dout_r = 1'($urandom_range(0, 1));
            din1 = $urandom; din2 = $urandom;
            op = 4'($urandom_range(0, 15));
            step();
        end
        drain();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
